// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, idle/initial line
// values and small decode helpers.
package keypad_pkg;
    typedef enum logic [1:0] {
        ST_SCAN         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

    localparam logic [3:0] ROW_INIT = 4'b1110;
    localparam logic [3:0] COL_IDLE = 4'b1111;

    function automatic logic is_onehot_low(input logic [3:0] v);
        return $countones(~v) == 1;
    endfunction

    function automatic logic [1:0] row_to_idx(input logic [3:0] r);
        logic [1:0] idx;
        case (r)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Lowest-index low column wins when several keys share the driven row.
    function automatic logic [1:0] low_col_idx(input logic [3:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!c[i]) idx = 2'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/keypad_cntr_if.sv
// Keypad lines plus decoded key outputs; the scanner drives rows and key status.
interface keypad_cntr_if;
    logic [3:0] column;
    logic [3:0] row;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_pedge;
    logic       key_nedge;

    modport master (
        output column,
        input  row, key_value, key_valid, key_pedge, key_nedge
    );
    modport slave (
        input  column,
        output row, key_value, key_valid, key_pedge, key_nedge
    );
endinterface

// File: rtl/keypad_cntr_scan_tick_gen.sv
// Free-running divider; tick is high for one clk after divider bit SCAN_DIV_BIT rises.
module scan_tick_gen #(
    parameter int SCAN_DIV_BIT = 16
) (
    input  logic clk,
    input  logic reset_p,
    output logic tick
);
    localparam logic [SCAN_DIV_BIT:0] DIV_ONE = 1;

    logic [SCAN_DIV_BIT:0] div;
    logic                  msb_q;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            div   <= '0;
            msb_q <= 1'b0;
        end else begin
            div   <= div + DIV_ONE;
            msb_q <= div[SCAN_DIV_BIT];
        end
    end

    assign tick = div[SCAN_DIV_BIT] & ~msb_q;
endmodule

// File: rtl/keypad_cntr.sv
// 4x4 keypad scanner: rotates an active-low row, debounces press and release on
// scan ticks, and reports the confirmed key with level and edge outputs.
module keypad_cntr
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BIT   = 16,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic         clk,
    input  logic         reset_p,
    keypad_cntr_if.slave kp
);
    localparam int             CW       = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0]  CNT_DONE = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic          tick;
    logic [3:0]    col_m, col_s;
    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    col_lat, col_lat_n;
    logic [3:0]    row_q, row_n;
    logic [3:0]    key_value_q, key_value_n;
    logic          valid_q, valid_n;
    logic          pedge_q, pedge_n;
    logic          nedge_q, nedge_n;
    logic          col_idle, col_same, cnt_hit;

    scan_tick_gen #(.SCAN_DIV_BIT(SCAN_DIV_BIT)) u_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .tick    (tick)
    );

    // Columns come straight from the switches, so they are synchronized first.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            col_m <= COL_IDLE;
            col_s <= COL_IDLE;
        end else begin
            col_m <= kp.column;
            col_s <= col_m;
        end
    end

    assign col_idle = (col_s == COL_IDLE);
    assign col_same = (col_s == col_lat);
    assign cnt_inc  = cnt + CNT_ONE;
    assign cnt_hit  = (cnt_inc == CNT_DONE);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state       <= ST_SCAN;
            cnt         <= '0;
            col_lat     <= COL_IDLE;
            row_q       <= ROW_INIT;
            key_value_q <= 4'h0;
            valid_q     <= 1'b0;
            pedge_q     <= 1'b0;
            nedge_q     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            col_lat     <= col_lat_n;
            // A corrupted row pattern self-heals to the first row.
            row_q       <= is_onehot_low(row_q) ? row_n : ROW_INIT;
            key_value_q <= key_value_n;
            valid_q     <= valid_n;
            pedge_q     <= pedge_n;
            nedge_q     <= nedge_n;
        end
    end

    always_comb begin
        state_n = state;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (!col_idle) state_n = ST_DEBOUNCE;
                end
                ST_DEBOUNCE: begin
                    if (!col_same)    state_n = ST_SCAN;
                    else if (cnt_hit) state_n = ST_PRESSED;
                end
                ST_PRESSED: begin
                    if (col_idle) state_n = ST_RELEASE_WAIT;
                end
                ST_RELEASE_WAIT: begin
                    if (!col_idle)    state_n = ST_PRESSED;
                    else if (cnt_hit) state_n = ST_SCAN;
                end
                default: state_n = ST_SCAN;
            endcase
        end
    end

    always_comb begin
        cnt_n       = cnt;
        col_lat_n   = col_lat;
        row_n       = row_q;
        key_value_n = key_value_q;
        valid_n     = valid_q;
        pedge_n     = 1'b0;
        nedge_n     = 1'b0;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (col_idle) begin
                        row_n = {row_q[2:0], row_q[3]};
                    end else begin
                        col_lat_n = col_s;
                        cnt_n     = '0;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!col_same) begin
                        cnt_n = '0;
                    end else if (cnt_hit) begin
                        cnt_n       = '0;
                        key_value_n = {row_to_idx(row_q), low_col_idx(col_lat)};
                        valid_n     = 1'b1;
                        pedge_n     = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (col_idle) cnt_n = '0;
                end
                ST_RELEASE_WAIT: begin
                    if (!col_idle) begin
                        cnt_n = '0;
                    end else if (cnt_hit) begin
                        cnt_n   = '0;
                        valid_n = 1'b0;
                        nedge_n = 1'b1;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: cnt_n = '0;
            endcase
        end
    end

    assign kp.row       = row_q;
    assign kp.key_value = key_value_q;
    assign kp.key_valid = valid_q;
    assign kp.key_pedge = pedge_q;
    assign kp.key_nedge = nedge_q;
endmodule

// File: tb/tb_keypad_cntr.sv
// Keypad scanner bench: a switch-matrix model drives the columns from the row lines.
module tb_keypad_cntr;
    localparam int DIV = 2;
    localparam int DEB = 3;
    localparam int P   = 1 << (DIV + 1);

    logic clk = 1'b0;
    logic reset_p;
    logic [15:0] keys = 16'h0;   // bit r*4+c = key at row r, column c held down
    always #5 clk = ~clk;

    keypad_cntr_if kp();

    keypad_cntr #(.SCAN_DIV_BIT(DIV), .DEBOUNCE_TICKS(DEB)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .kp      (kp)
    );

    function automatic logic [3:0] col_of(input logic [15:0] k, input logic [3:0] r);
        logic [3:0] c;
        c = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (!r[rr] && k[rr*4+cc]) c[cc] = 1'b0;
        return c;
    endfunction

    assign kp.column = col_of(keys, kp.row);

    int tests = 0, fails = 0;
    int pe_cnt = 0, ne_cnt = 0, both_cnt = 0;

    always @(posedge clk) begin
        if (kp.key_pedge) pe_cnt <= pe_cnt + 1;
        if (kp.key_nedge) ne_cnt <= ne_cnt + 1;
        if (kp.key_pedge && kp.key_nedge) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: explicit per-tick rules on plain integers.
    localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;
    int         m_mode, m_ridx, m_cnt, m_n;
    logic [3:0] m_lat, m_s1, m_s2, m_kv;
    logic       m_valid, m_pe, m_ne;

    function automatic logic [3:0] m_row();
        return ~(4'b0001 << m_ridx);
    endfunction

    task automatic model_reset();
        m_mode = M_SCAN; m_ridx = 0; m_cnt = 0; m_n = 0;
        m_lat = 4'hF; m_s1 = 4'hF; m_s2 = 4'hF; m_kv = 4'h0;
        m_valid = 1'b0; m_pe = 1'b0; m_ne = 1'b0;
    endtask

    // One clk edge. The divider bit rises at count P/2; the controller acts one edge later.
    task automatic model_edge(input logic [3:0] col);
        logic [3:0] cs;
        int lc;
        cs = m_s2; m_s2 = m_s1; m_s1 = col;
        m_n++;
        m_pe = 1'b0; m_ne = 1'b0;
        if (m_n % P == P/2 + 1) begin
            case (m_mode)
                M_SCAN: if (cs == 4'hF) m_ridx = (m_ridx + 1) % 4;
                        else begin m_lat = cs; m_cnt = 0; m_mode = M_DEB; end
                M_DEB: if (cs == m_lat) begin
                           m_cnt++;
                           if (m_cnt == DEB) begin
                               lc = 0;
                               for (int c = 3; c >= 0; c--) if (!m_lat[c]) lc = c;
                               m_kv = 4'(m_ridx * 4 + lc);
                               m_valid = 1'b1; m_pe = 1'b1; m_mode = M_HELD;
                           end
                       end else begin m_cnt = 0; m_mode = M_SCAN; end
                M_HELD: if (cs == 4'hF) begin m_cnt = 0; m_mode = M_REL; end
                default: if (cs == 4'hF) begin
                             m_cnt++;
                             if (m_cnt == DEB) begin
                                 m_valid = 1'b0; m_ne = 1'b1; m_mode = M_SCAN;
                             end
                         end else m_mode = M_HELD;
            endcase
        end
    endtask

    typedef struct {
        logic [15:0] keys;
        int          nclk;
        logic        chk_row;
        logic [3:0]  row;
        logic        valid;
        logic [3:0]  value;
        int          pe;
        int          ne;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int pe0, ne0, changes, bad, waited, seg_left;
        logic [3:0] prev;

        vecs[0] = '{16'h0200, 100, 1'b1, 4'b1011, 1'b1, 4'h9, 1, 0};
        vecs[1] = '{16'h0000,  60, 1'b0, 4'b1111, 1'b0, 4'h9, 0, 1};
        vecs[2] = '{16'h000A, 100, 1'b1, 4'b1110, 1'b1, 4'h1, 1, 0};
        vecs[3] = '{16'h0000,  60, 1'b0, 4'b1111, 1'b0, 4'h1, 0, 1};
        vecs[4] = '{16'h0040, 100, 1'b1, 4'b1101, 1'b1, 4'h6, 1, 0};
        vecs[5] = '{16'h0000,  60, 1'b0, 4'b1111, 1'b0, 4'h6, 0, 1};
        vecs[6] = '{16'h8000, 100, 1'b1, 4'b0111, 1'b1, 4'hF, 1, 0};
        vecs[7] = '{16'h0000,  60, 1'b0, 4'b1111, 1'b0, 4'hF, 0, 1};

        // Reset state
        reset_p = 1'b1;
        repeat (3) @(negedge clk);
        check("rst row",   kp.row, 4'b1110);
        check("rst value", kp.key_value, 4'h0);
        check("rst valid", kp.key_valid, 1'b0);
        check("rst pedge", kp.key_pedge, 1'b0);
        check("rst nedge", kp.key_nedge, 1'b0);
        reset_p = 1'b0;

        // Idle scan: rotate-left once per tick, no key activity
        prev = kp.row; changes = 0; bad = 0; pe0 = pe_cnt; ne0 = ne_cnt;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (kp.row !== prev) begin
                changes++;
                if (kp.row !== {prev[2:0], prev[3]}) bad++;
                prev = kp.row;
            end
            if (kp.key_valid !== 1'b0) bad++;
        end
        check("idle rotations", changes, 8);
        check("idle bad steps", bad, 0);
        check("idle pedges", pe_cnt - pe0, 0);
        check("idle nedges", ne_cnt - ne0, 0);

        // Table: press/release of single and double keys
        foreach (vecs[v]) begin
            pe0 = pe_cnt; ne0 = ne_cnt;
            keys = vecs[v].keys;
            repeat (vecs[v].nclk) @(negedge clk);
            if (vecs[v].chk_row) check($sformatf("vec%0d row", v), kp.row, vecs[v].row);
            check($sformatf("vec%0d valid", v), kp.key_valid, vecs[v].valid);
            check($sformatf("vec%0d value", v), kp.key_value, vecs[v].value);
            check($sformatf("vec%0d pedges", v), pe_cnt - pe0, vecs[v].pe);
            check($sformatf("vec%0d nedges", v), ne_cnt - ne0, vecs[v].ne);
        end

        // Bounce on row 3 col 0: brief contact, gap, then steady hold
        pe0 = pe_cnt; ne0 = ne_cnt;
        keys = 16'h1000;
        waited = 0;
        while (kp.row !== 4'b0111 && waited < 64) begin @(negedge clk); waited++; end
        check("bounce row reached", waited < 64, 1'b1);
        repeat (12) @(negedge clk);
        keys = 16'h0000;
        repeat (8) @(negedge clk);
        check("bounce no early pedge", pe_cnt - pe0, 0);
        keys = 16'h1000;
        repeat (100) @(negedge clk);
        check("bounce one pedge", pe_cnt - pe0, 1);
        check("bounce value", kp.key_value, 4'hC);
        check("bounce valid", kp.key_valid, 1'b1);
        keys = 16'h0000;
        repeat (60) @(negedge clk);
        check("bounce nedge", ne_cnt - ne0, 1);

        // Reset while a key is held: no release pulse afterwards
        keys = 16'h0020;
        waited = 0;
        while (kp.key_valid !== 1'b1 && waited < 120) begin @(negedge clk); waited++; end
        check("midpress valid reached", waited < 120, 1'b1);
        reset_p = 1'b1; keys = 16'h0000;
        @(negedge clk);
        reset_p = 1'b0;
        check("midpress row", kp.row, 4'b1110);
        check("midpress valid", kp.key_valid, 1'b0);
        check("midpress value", kp.key_value, 4'h0);
        pe0 = pe_cnt; ne0 = ne_cnt;
        repeat (60) @(negedge clk);
        check("midpress no nedge", ne_cnt - ne0, 0);
        check("midpress no pedge", pe_cnt - pe0, 0);

        // Randomized key activity against the reference model, cycle by cycle
        reset_p = 1'b1; keys = 16'h0000;
        @(negedge clk);
        reset_p = 1'b0;
        model_reset();
        for (int seg = 0; seg < 30; seg++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: keys = 16'h0000;
                9:       keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                default: keys = 16'h1 << $urandom_range(0, 15);
            endcase
            seg_left = $urandom_range(3, 70);
            repeat (seg_left) begin
                check("rand cycle",
                      {kp.row, kp.key_value, kp.key_valid, kp.key_pedge, kp.key_nedge},
                      {m_row(), m_kv, m_valid, m_pe, m_ne});
                model_edge(col_of(keys, m_row()));
                @(negedge clk);
            end
        end

        check("pedge and nedge together", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/keypad_cntr.md
KEYPAD_CNTR -- requirements
Module: keypad_cntr

Interface
REQ-001 SHALL have parameter SCAN_DIV_BIT, default 16; the scan tick fires on each rising edge of free-running divider bit SCAN_DIV_BIT (period 2^(SCAN_DIV_BIT+1) clk).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 8; the number of consecutive stable scan ticks that confirms a press or a release.
REQ-003 SHALL have port: clk  input  1  system clock; the only clock.
REQ-004 SHALL have port: reset_p  input  1  reset, synchronous to clk, active-high.
REQ-005 SHALL have port: column  input  4  keypad column lines, active-low, idle 4'b1111, asynchronous.
REQ-006 SHALL have port: row  output  4  keypad row drive, active-low, exactly one bit low.
REQ-007 SHALL have port: key_value  output  4  code of the confirmed key, {row_idx[1:0], col_idx[1:0]}.
REQ-008 SHALL have port: key_valid  output  1  level, high while the confirmed key is held.
REQ-009 SHALL have port: key_pedge  output  1  one-clk pulse when a press is confirmed.
REQ-010 SHALL have port: key_nedge  output  1  one-clk pulse when a release is confirmed.

Function
REQ-011 SHALL pass column through a 2-flop synchronizer; all decisions use the synchronized value (col_s).
REQ-012 SHALL hold row_idx 0..3 for row = 4'b1110, 4'b1101, 4'b1011, 4'b0111; col_idx j for col_s[j] = 0.
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, RELEASE_WAIT.
REQ-014 SCAN: on each tick, if col_s == 4'b1111, rotate row left (1110->1101->1011->0111->1110); otherwise freeze row, latch col_s, clear stable count, go to DEBOUNCE.
REQ-015 DEBOUNCE: on each tick, if col_s equals the latched value, increment count; else return to SCAN with count 0 and row unchanged.
REQ-016 When the count reaches DEBOUNCE_TICKS, SHALL go to PRESSED, load key_value, set key_valid, and pulse key_pedge for one clk on the next clk edge.
REQ-017 If several columns are low, SHALL encode the lowest-index low column.
REQ-018 PRESSED: row stays frozen; on a tick with col_s == 4'b1111, go to RELEASE_WAIT with count 0; other column changes are ignored.
REQ-019 RELEASE_WAIT: on a tick with col_s == 4'b1111, increment count; on a tick with any column low, return to PRESSED.
REQ-020 When the count reaches DEBOUNCE_TICKS, SHALL clear key_valid, pulse key_nedge for one clk, and go to SCAN; key_value holds its last code.
REQ-021 Any row value that is not one-hot-low SHALL be replaced by 4'b1110 on the next clk.
REQ-022 key_pedge and key_nedge SHALL never be high in the same cycle.

Reset
REQ-023 While reset_p is high at a clk edge: row=4'b1110, state=SCAN, divider=0, count=0, synchronizer=4'b1111, key_value=0, key_valid=0, key_pedge=0, key_nedge=0.
REQ-024 Reset asserted in any state, including mid-debounce or mid-press, SHALL abort with no key_nedge pulse.

Structure
REQ-025 Shared package keypad_pkg SHALL hold the state encoding, ROW_INIT=4'b1110 and COL_IDLE=4'b1111.
REQ-026 The divider and tick pulse SHALL be a sub-module scan_tick_gen (params: SCAN_DIV_BIT; ports: clk, reset_p, tick).

Verification (SCAN_DIV_BIT=2, tick every 8 clk; DEBOUNCE_TICKS=3)
REQ-027 Idle: column=4'b1111 for 64 clk -> row cycles 1110,1101,1011,0111,1110 once per 8 clk; all key outputs stay 0.
REQ-028 Press row 2 col 1: column=4'b1101 while row=4'b1011, held -> row frozen at 1011; after 3 more ticks key_value=4'h9, key_valid=1, one key_pedge pulse.
REQ-029 Release: column returns to 4'b1111 -> key_nedge pulses once 3 ticks after the first idle tick; key_valid=0; key_value stays 4'h9; scan resumes.
REQ-030 Bounce: column low for 1 tick, high, then low again -> no key_pedge until 3 consecutive stable ticks; exactly one pulse in total.
REQ-031 Two columns: column=4'b0101 on row 0 -> key_value=4'h1.
REQ-032 Reset mid-press: reset_p high for 1 clk while in PRESSED -> next cycle row=4'b1110, key_valid=0, key_nedge never pulses.
